// File: rtl/path_replay_pkg.sv
// path_replay_pkg
// Shared definitions for the maze-solver replay path:
//   - bits()        : address width needed to index x entries (min 1)
//   - DIR_*         : 2-bit move direction encodings shared with the solver
//   - state_t       : path_replay FSM state encoding
package path_replay_pkg;

    // Width of an index into an x-entry array; never returns 0 so that
    // degenerate sizes still produce legal vectors.
    function automatic int bits(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    localparam logic [1:0] DIR_UP    = 2'b00;  // y-1
    localparam logic [1:0] DIR_RIGHT = 2'b01;  // x+1
    localparam logic [1:0] DIR_LEFT  = 2'b10;  // x-1
    localparam logic [1:0] DIR_DOWN  = 2'b11;  // y+1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_EMIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/path_replay_move_step.sv
// path_replay_move_step
// Combinational single-cell stepper: applies one move direction to an
// (x,y) coordinate. Arithmetic wraps modulo 2^CW with no bounds check.
// The solver instantiates the same stepper for its own position tracking.
// Ports:
//   x, y   in  CW  current cell
//   dir    in  2   move direction (DIR_UP/RIGHT/LEFT/DOWN)
//   nx, ny out CW  cell after the move
module path_replay_move_step
    import path_replay_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [1:0]    dir,
    output logic [CW-1:0] nx,
    output logic [CW-1:0] ny
);

    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = y - CW'(1);
            DIR_RIGHT: nx = x + CW'(1);
            DIR_LEFT:  nx = x - CW'(1);
            default:   ny = y + CW'(1);
        endcase
    end

endmodule

// File: rtl/path_replay.sv
// path_replay
// Drains the direction stack (last move first) into a local buffer, then
// replays the moves in forward order on a valid/ready stream together with
// the running cell coordinate after each move.
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   start       pulse that begins drain-and-replay (honoured in IDLE/DONE)
//   stk_empty   stack empty flag
//   stk_dout    stack data, valid the cycle after a sampled pop
//   stk_pop     pop request to the stack (DRAIN only)
//   mv_valid/mv_ready   move stream handshake
//   mv_dir      move direction
//   mv_x, mv_y  coordinate after applying mv_dir
//   mv_last     high with the final move
//   count       number of moves drained
//   done        replay complete, held in DONE
module path_replay
    import path_replay_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 256,
    parameter int CW      = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stk_empty,
    input  logic [WIDTH-1:0]       stk_dout,
    output logic                   stk_pop,
    output logic                   mv_valid,
    input  logic                   mv_ready,
    output logic [WIDTH-1:0]       mv_dir,
    output logic [CW-1:0]          mv_x,
    output logic [CW-1:0]          mv_y,
    output logic                   mv_last,
    output logic [bits(DEPTH):0]   count,
    output logic                   done
);

    localparam int AW   = bits(DEPTH);
    localparam int CNTW = AW + 1;

    state_t            state;
    logic [CNTW-1:0]   count_reg;
    logic [AW-1:0]     rd_ptr;
    logic              pop_d;
    logic [CW-1:0]     pos_x;
    logic [CW-1:0]     pos_y;
    logic              done_reg;

    // Move buffer: written during DRAIN, read through a registered port.
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  dir_reg;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [CNTW-1:0]   count_m1;

    logic [CW-1:0]     step_x;
    logic [CW-1:0]     step_y;
    logic              drain_exit;
    logic              handshake;

    assign count_m1   = count_reg - CNTW'(1);
    // Exit only once no capture is pending, so count is final here.
    assign drain_exit = (state == ST_DRAIN) && stk_empty && !pop_d;
    assign handshake  = (state == ST_EMIT) && mv_ready;

    assign stk_pop  = (state == ST_DRAIN) && !stk_empty;
    assign mv_valid = (state == ST_EMIT);
    assign mv_last  = (state == ST_EMIT) && (rd_ptr == '0);
    assign mv_dir   = mv_valid ? dir_reg : '0;
    assign mv_x     = mv_valid ? step_x  : '0;
    assign mv_y     = mv_valid ? step_y  : '0;
    assign count    = count_reg;
    assign done     = done_reg;

    // The next move is fetched one cycle ahead: on the DRAIN->EMIT
    // transition (first forward move) and on each non-final handshake,
    // so dir_reg always holds buf[rd_ptr] while in EMIT.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = rd_ptr - AW'(1);
        if (drain_exit && (count_reg != '0)) begin
            rd_en   = 1'b1;
            rd_addr = count_m1[AW-1:0];
        end else if (handshake && (rd_ptr != '0)) begin
            rd_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_DRAIN) && pop_d) begin
            mem[count_reg[AW-1:0]] <= stk_dout;
        end
        if (rd_en) begin
            dir_reg <= mem[rd_addr];
        end
    end

    path_replay_move_step #(
        .CW (CW)
    ) u_step (
        .x   (pos_x),
        .y   (pos_y),
        .dir (dir_reg[1:0]),
        .nx  (step_x),
        .ny  (step_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count_reg <= '0;
            rd_ptr    <= '0;
            pop_d     <= 1'b0;
            pos_x     <= CW'(START_X);
            pos_y     <= CW'(START_Y);
            done_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_DRAIN;
                        count_reg <= '0;
                        pop_d     <= 1'b0;
                        pos_x     <= CW'(START_X);
                        pos_y     <= CW'(START_Y);
                        done_reg  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    pop_d <= stk_pop;
                    if (pop_d) begin
                        count_reg <= count_reg + CNTW'(1);
                    end else if (stk_empty) begin
                        if (count_reg == '0) begin
                            state    <= ST_DONE;
                            done_reg <= 1'b1;
                        end else begin
                            state  <= ST_EMIT;
                            rd_ptr <= count_m1[AW-1:0];
                        end
                    end
                end
                ST_EMIT: begin
                    if (mv_ready) begin
                        pos_x <= step_x;
                        pos_y <= step_y;
                        if (rd_ptr == '0) begin
                            state    <= ST_DONE;
                            done_reg <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr - AW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
